// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1x3 router synchroniser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         NUM_PORTS    = 3;
    localparam int         TIMEOUT_DEF  = 30;
    localparam int         CNT_W_DEF    = 5;

    // One-hot FIFO select for a header address; the invalid address selects nothing.
    function automatic logic [NUM_PORTS-1:0] addr_onehot(input logic [1:0] addr);
        logic [NUM_PORTS-1:0] sel;
        sel = '0;
        case (addr)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port unread-data watchdog: pulses soft_reset when valid data sits unread for TIMEOUT edges.
// Latency: soft_reset is registered, high for one cycle after the TIMEOUT-th consecutive idle edge.
// Backpressure: none; any read strobe restarts the window.
module router_sync_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             idle;

    // Data is waiting and nobody is draining it this cycle.
    assign idle = vld & ~rd;

    // Count consecutive idle edges; flush and restart the window when it reaches TIMEOUT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            soft_reset <= 1'b0;
        end else if (!idle) begin
            cnt_q      <= '0;
            soft_reset <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q      <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt_q      <= cnt_q + 1'b1;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync.sv
// Router synchroniser: latches packet address, steers FSM write strobe, returns addressed full flag.
// Latency: address latched on detect_add edge; write_enb/fifo_full/vld_out are combinational.
// Backpressure: fifo_full of the addressed FIFO stalls the FSM; invalid address never stalls.
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    logic [1:0] addr_q;

    // Capture the destination from the header byte; reset parks it on the invalid address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= ADDR_INVALID;
        end else if (detect_add) begin
            addr_q <= data_in;
        end
    end

    // Steer the write strobe by the registered address, so a same-cycle header uses the old one.
    always_comb begin
        write_enb = 3'b000;
        if (write_enb_reg) begin
            write_enb = addr_onehot(addr_q);
        end
    end

    // Return the addressed FIFO's full flag; an invalid packet must never stall the FSM.
    always_comb begin
        fifo_full = 1'b0;
        case (addr_q)
            2'd0:    fifo_full = full_0;
            2'd1:    fifo_full = full_1;
            2'd2:    fifo_full = full_2;
            default: fifo_full = 1'b0;
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_0 (
        .clock      (clock),
        .reset      (reset),
        .vld        (vld_out_0),
        .rd         (read_enb_0),
        .soft_reset (soft_reset_0)
    );

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_1 (
        .clock      (clock),
        .reset      (reset),
        .vld        (vld_out_1),
        .rd         (read_enb_1),
        .soft_reset (soft_reset_1)
    );

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_2 (
        .clock      (clock),
        .reset      (reset),
        .vld        (vld_out_2),
        .rd         (read_enb_2),
        .soft_reset (soft_reset_2)
    );

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: vector table for steering, sequences for watchdog and reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Backpressure: n/a.
module tb_router_sync;

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    router_sync dut (
        .clock         (clock),
        .reset         (reset),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb_0    (read_enb_0),
        .read_enb_1    (read_enb_1),
        .read_enb_2    (read_enb_2),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    typedef struct {
        logic       da;
        logic [1:0] din;
        logic       we;
        logic [2:0] full;   // {full_2, full_1, full_0}
        logic [2:0] empty;  // {empty_2, empty_1, empty_0}
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_vld; // {vld_out_2, vld_out_1, vld_out_0}
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Observe n edges; report first edge index (or -1) and number of pulses per port.
    task automatic watch(input int n, output int f0, output int c0, output int f1,
                         output int c1, output int f2, output int c2);
        f0 = -1; f1 = -1; f2 = -1; c0 = 0; c1 = 0; c2 = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (soft_reset_0) begin c0++; if (f0 < 0) f0 = k; end
            if (soft_reset_1) begin c1++; if (f1 < 0) f1 = k; end
            if (soft_reset_2) begin c2++; if (f2 < 0) f2 = k; end
        end
    endtask

    task automatic idle_all();
        detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
        full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    endtask

    initial begin
        int f0, c0, f1, c1, f2, c2;

        //        da din  we full    empty   exp_we  ff  exp_vld
        tbl[0]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000}; // invalid after reset
        tbl[1]  = '{1'b1, 2'd1, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0, 3'b001}; // latch addr 1
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 3'b000, 3'b101, 3'b010, 1'b0, 3'b010};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 3'b010, 3'b011, 3'b010, 1'b1, 3'b100};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 3'b101, 3'b000, 3'b010, 1'b0, 3'b111};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 3'b111, 3'b111, 3'b000, 1'b1, 3'b000};
        tbl[6]  = '{1'b1, 2'd3, 1'b1, 3'b111, 3'b111, 3'b010, 1'b1, 3'b000}; // old addr 1 steers
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000}; // invalid packet
        tbl[8]  = '{1'b1, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000}; // latch addr 0
        tbl[9]  = '{1'b1, 2'd2, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000}; // same-cycle: old addr 0
        tbl[10] = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b111, 3'b100, 1'b0, 3'b000}; // now addr 2
        tbl[11] = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};

        // Reset state, checked while reset is held and inputs would otherwise drive outputs.
        idle_all();
        reset = 1'b1;
        write_enb_reg = 1'b1; full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        #12;
        chk("rst_write_enb", int'(write_enb), 0);
        chk("rst_fifo_full", int'(fifo_full), 0);
        chk("rst_soft_reset", int'({soft_reset_2, soft_reset_1, soft_reset_0}), 0);
        step();
        reset = 1'b0;
        idle_all();
        step();

        // Steering table; read strobes held high so the watchdogs never count.
        read_enb_0 = 1'b1; read_enb_1 = 1'b1; read_enb_2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            detect_add    = tbl[i].da;
            data_in       = tbl[i].din;
            write_enb_reg = tbl[i].we;
            {full_2, full_1, full_0}    = tbl[i].full;
            {empty_2, empty_1, empty_0} = tbl[i].empty;
            #1;
            chk($sformatf("vec%0d_write_enb", i), int'(write_enb), int'(tbl[i].exp_we));
            chk($sformatf("vec%0d_fifo_full", i), int'(fifo_full), int'(tbl[i].exp_ff));
            chk($sformatf("vec%0d_vld_out", i), int'({vld_out_2, vld_out_1, vld_out_0}),
                int'(tbl[i].exp_vld));
            step();
        end
        idle_all();
        step();

        // Port 0 watchdog: pulse exactly once, on the 30th idle edge.
        empty_0 = 1'b0;
        watch(40, f0, c0, f1, c1, f2, c2);
        chk("to0_first_edge", f0, 30);
        chk("to0_pulse_count", c0, 1);
        chk("to0_port1_quiet", c1, 0);
        idle_all();
        step();

        // A read on the 29th edge cancels the window; the next pulse is 30 edges later.
        empty_0 = 1'b0;
        watch(28, f0, c0, f1, c1, f2, c2);
        read_enb_0 = 1'b1;
        step();
        if (soft_reset_0) c0++;
        chk("rd29_no_pulse", c0, 0);
        read_enb_0 = 1'b0;
        watch(35, f0, c0, f1, c1, f2, c2);
        chk("rd29_restart_edge", f0, 30);
        chk("rd29_restart_count", c0, 1);
        idle_all();
        step();

        // Simultaneous timeouts on ports 0 and 2; port 1 stays empty.
        empty_0 = 1'b0; empty_2 = 1'b0;
        watch(35, f0, c0, f1, c1, f2, c2);
        chk("sim_port0_edge", f0, 30);
        chk("sim_port2_edge", f2, 30);
        chk("sim_port1_count", c1, 0);
        idle_all();
        step();

        // Mid-packet, mid-count async reset: addr 2 latched, port 0 ten edges into its window.
        detect_add = 1'b1; data_in = 2'd2;
        step();
        detect_add = 1'b0;
        empty_0 = 1'b0;
        watch(40, f0, c0, f1, c1, f2, c2);
        write_enb_reg = 1'b1; full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        #1;
        chk("pre_rst_write_enb", int'(write_enb), 4);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_write_enb", int'(write_enb), 0);
        chk("mid_rst_fifo_full", int'(fifo_full), 0);
        chk("mid_rst_soft_reset", int'({soft_reset_2, soft_reset_1, soft_reset_0}), 0);
        step();
        reset = 1'b0;
        write_enb_reg = 1'b0; full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
        watch(35, f0, c0, f1, c1, f2, c2);
        chk("post_rst_count_from0", f0, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "bench timeout");
    end

endmodule
